// File: rtl/alu_pkg.sv
// Shared constants for the ALU/register datapath slice: default width and
// the ALU opcode encoding (bit 2 selects logic vs arithmetic).
package alu_pkg;

    localparam int DATA_W_DEF = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_INC = 3'b010,
        OP_DEC = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_NOT = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_reg_slice_if.sv
// Bundle of ALU operand/result and register control/data signals.
// master drives the operands and controls; slave is the slice itself.
interface alu_reg_slice_if #(
    parameter int DATA_W = alu_pkg::DATA_W_DEF
);
    logic [2:0]        alu_oc;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_f;
    logic              cl;
    logic              ld;
    logic              inc;
    logic              dec;
    logic              sr;
    logic              ir;
    logic              sl;
    logic              il;
    logic [DATA_W-1:0] reg_in;
    logic [DATA_W-1:0] reg_out;

    modport master (
        output alu_oc, alu_a, alu_b, cl, ld, inc, dec, sr, ir, sl, il, reg_in,
        input  alu_f, reg_out
    );

    modport slave (
        input  alu_oc, alu_a, alu_b, cl, ld, inc, dec, sr, ir, sl, il, reg_in,
        output alu_f, reg_out
    );
endinterface

// File: rtl/alu_reg_slice_alu.sv
// Purely combinational ALU; every result wraps modulo 2^DATA_W, no flags.
module alu_reg_slice_alu
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        oc,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] f
);

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    always_comb begin
        f = '0;
        case (alu_op_e'(oc))
            OP_ADD:  f = a + b;
            OP_SUB:  f = a - b;
            OP_INC:  f = a + ONE;
            OP_DEC:  f = a - ONE;
            OP_AND:  f = a & b;
            OP_OR:   f = a | b;
            OP_XOR:  f = a ^ b;
            OP_NOT:  f = ~a;
            default: f = '0;
        endcase
    end

endmodule

// File: rtl/alu_reg_slice_reg.sv
// Multi-function register: clear > load > inc > dec > shift right > shift left > hold.
module alu_reg_slice_reg
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cl,
    input  logic              ld,
    input  logic              inc,
    input  logic              dec,
    input  logic              sr,
    input  logic              ir,
    input  logic              sl,
    input  logic              il,
    input  logic [DATA_W-1:0] reg_in,
    output logic [DATA_W-1:0] reg_out
);

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] out_d;
    logic [DATA_W-1:0] out_q;

    // Exactly one action per edge; lower-priority controls are ignored.
    always_comb begin
        out_d = out_q;
        if (cl)       out_d = '0;
        else if (ld)  out_d = reg_in;
        else if (inc) out_d = out_q + ONE;
        else if (dec) out_d = out_q - ONE;
        else if (sr)  out_d = {ir, out_q[DATA_W-1:1]};
        else if (sl)  out_d = {out_q[DATA_W-2:0], il};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= out_d;
    end

    assign reg_out = out_q;

endmodule

// File: rtl/alu_reg_slice.sv
// Datapath slice top: an ALU and a register side by side with no internal
// connection; the enclosing datapath decides how they are wired together.
module alu_reg_slice
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input logic           clk,
    input logic           rst_n,
    alu_reg_slice_if.slave bus
);

    alu_reg_slice_alu #(.DATA_W(DATA_W)) u_alu (
        .oc (bus.alu_oc),
        .a  (bus.alu_a),
        .b  (bus.alu_b),
        .f  (bus.alu_f)
    );

    alu_reg_slice_reg #(.DATA_W(DATA_W)) u_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .cl      (bus.cl),
        .ld      (bus.ld),
        .inc     (bus.inc),
        .dec     (bus.dec),
        .sr      (bus.sr),
        .ir      (bus.ir),
        .sl      (bus.sl),
        .il      (bus.il),
        .reg_in  (bus.reg_in),
        .reg_out (bus.reg_out)
    );

endmodule

// File: tb/tb_alu_reg_slice.sv
// Self-checking bench for alu_reg_slice: ALU vectors and sweep, register
// vector table, asynchronous reset sequence and random register traffic.
module tb_alu_reg_slice;

    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   m;

    alu_reg_slice_if #(.DATA_W(W)) bus ();

    alu_reg_slice #(.DATA_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string      name;
        logic [2:0] oc;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] f;
    } alu_vec_t;

    // ctrl = {cl, ld, inc, dec, sr, ir, sl, il}
    typedef struct {
        string      name;
        logic [7:0] ctrl;
        logic [3:0] din;
        logic [3:0] exp;
    } reg_vec_t;

    alu_vec_t alu_tab[6];
    reg_vec_t reg_tab[13];

    function automatic int alu_model(input int oc, input int a, input int b);
        int r;
        case (oc)
            0: r = a + b;
            1: r = a - b + 16;
            2: r = a + 1;
            3: r = a + 15;
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            default: r = 15 - a;
        endcase
        return r % 16;
    endfunction

    function automatic int reg_model(input int cur, input logic [7:0] c, input int din);
        if (c[7]) return 0;
        if (c[6]) return din;
        if (c[5]) return (cur + 1) % 16;
        if (c[4]) return (cur + 15) % 16;
        if (c[3]) return (cur / 2) + (c[2] ? 8 : 0);
        if (c[1]) return (cur * 2) % 16 + (c[0] ? 1 : 0);
        return cur;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%b exp=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic drive_ctrl(input logic [7:0] c, input logic [3:0] din);
        {bus.cl, bus.ld, bus.inc, bus.dec, bus.sr, bus.ir, bus.sl, bus.il} = c;
        bus.reg_in = din;
    endtask

    task automatic reg_step(input string name, input logic [7:0] c, input logic [3:0] din,
                            input logic [3:0] exp);
        @(negedge clk);
        drive_ctrl(c, din);
        @(posedge clk);
        #1;
        check(name, bus.reg_out, exp);
    endtask

    task automatic alu_apply(input logic [2:0] oc, input logic [3:0] a, input logic [3:0] b);
        bus.alu_oc = oc;
        bus.alu_a  = a;
        bus.alu_b  = b;
        #1;
    endtask

    initial begin
        alu_tab[0] = '{"alu_add_wrap", 3'b000, 4'b1111, 4'b0001, 4'b0000};
        alu_tab[1] = '{"alu_sub_wrap", 3'b001, 4'b0000, 4'b0001, 4'b1111};
        alu_tab[2] = '{"alu_not",      3'b111, 4'b1010, 4'b0110, 4'b0101};
        alu_tab[3] = '{"alu_inc_wrap", 3'b010, 4'b1111, 4'b0011, 4'b0000};
        alu_tab[4] = '{"alu_dec_wrap", 3'b011, 4'b0000, 4'b1001, 4'b1111};
        alu_tab[5] = '{"alu_xor",      3'b110, 4'b1100, 4'b1010, 4'b0110};

        reg_tab[0]  = '{"ld_1111",      8'b0100_0000, 4'b1111, 4'b1111};
        reg_tab[1]  = '{"inc_wrap",     8'b0010_0000, 4'b0000, 4'b0000};
        reg_tab[2]  = '{"dec_wrap",     8'b0001_0000, 4'b0000, 4'b1111};
        reg_tab[3]  = '{"ld_1001",      8'b0100_0000, 4'b1001, 4'b1001};
        reg_tab[4]  = '{"sr_ir1",       8'b0000_1100, 4'b0000, 4'b1100};
        reg_tab[5]  = '{"sl_il0",       8'b0000_0010, 4'b0000, 4'b1000};
        reg_tab[6]  = '{"pri_cl_ld_inc",8'b1110_0000, 4'b0110, 4'b0000};
        reg_tab[7]  = '{"pri_ld_inc",   8'b0110_0000, 4'b0101, 4'b0101};
        reg_tab[8]  = '{"ld_0100",      8'b0100_0000, 4'b0100, 4'b0100};
        reg_tab[9]  = '{"pri_dec_sr",   8'b0001_1100, 4'b0000, 4'b0011};
        reg_tab[10] = '{"hold",         8'b0000_0101, 4'b1111, 4'b0011};
        reg_tab[11] = '{"sl_il1",       8'b0000_0011, 4'b0000, 4'b0111};
        reg_tab[12] = '{"sr_ir0",       8'b0000_1001, 4'b0000, 4'b0011};

        rst_n = 1'b0;
        drive_ctrl(8'h00, 4'h0);
        alu_apply(3'b000, 4'h0, 4'h0);
        check("reset_state", bus.reg_out, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU spot vectors
        for (int i = 0; i < 6; i++) begin
            alu_apply(alu_tab[i].oc, alu_tab[i].a, alu_tab[i].b);
            check(alu_tab[i].name, bus.alu_f, alu_tab[i].f);
        end

        // ALU exhaustive sweep, arithmetic half then logic half
        for (int oc = 0; oc < 8; oc++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    alu_apply(3'(oc), 4'(a), 4'(b));
                    check("alu_sweep", bus.alu_f, 4'(alu_model(oc, a, b)));
                end

        // register vector table
        for (int i = 0; i < 13; i++)
            reg_step(reg_tab[i].name, reg_tab[i].ctrl, reg_tab[i].din, reg_tab[i].exp);

        // asynchronous reset in the middle of a cycle with a load pending
        @(posedge clk);
        #2;
        drive_ctrl(8'b0100_0000, 4'b1010);
        rst_n = 1'b0;
        #1;
        check("rst_async", bus.reg_out, 4'b0000);
        @(posedge clk);
        #1;
        check("rst_hold", bus.reg_out, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_ld", bus.reg_out, 4'b1010);
        m = 10;

        // random traffic against the priority model
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] c;
            logic [3:0] din;
            c      = 8'($urandom);
            c[7]   = ($urandom_range(0, 15) == 0);
            c[6]   = ($urandom_range(0, 7) == 0);
            din    = 4'($urandom);
            m      = reg_model(m, c, int'(din));
            reg_step("random", c, din, 4'(m));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
